// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-side signals around the memory arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold requests until their wait drops; the RAM paces accesses with ram_ready.
//
// slave  : arbiter view (takes requests and RAM responses, drives waits, loads and RAM strobes)
// master : environment view (icache, dcache and RAM side)
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising icache reads and dcache reads/writes onto one single-ported RAM.
// Latency: grant registered in IDLE, strobes the next cycle, completion in the cycle ram_ready is seen.
// Backpressure: iwait/dwait stay high until the access completes; a mandatory IDLE cycle separates accesses.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      asynchronous reset, active high
//   bus      mem_arbiter_if.slave: icache (iREN/iaddr/iwait/iload), dcache (dREN/dWEN/daddr/dstore/
//            dwait/dload) and RAM (ramREN/ramWEN/ramaddr/ramstore/ramload/ram_ready)
module mem_arbiter #(
    parameter int WORD_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } req_t;

    state_t state;
    req_t   last_grant;

    logic i_pend;
    logic d_pend;
    logic d_wr;
    logic i_live;
    logic d_live;

    assign i_pend = bus.iREN;
    assign d_pend = bus.dREN | bus.dWEN;
    // A simultaneous read and write request is served as a write.
    assign d_wr   = bus.dWEN;

    // An access is live only while its requester still asserts the request; dropping it
    // mid-access pulls the strobes down in the same cycle (abort).
    assign i_live = (state == IACC) && i_pend;
    assign d_live = (state == DACC) && d_pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= ICACHE;
        end else begin
            case (state)
                IDLE: begin
                    // ram_ready is deliberately ignored here.
                    if (i_pend && d_pend) begin
                        state <= (last_grant == ICACHE) ? DACC : IACC;
                    end else if (i_pend) begin
                        state <= IACC;
                    end else if (d_pend) begin
                        state <= DACC;
                    end
                end
                IACC: begin
                    if (!i_pend) begin
                        // Abort: no completion, fairness history untouched.
                        state <= IDLE;
                    end else if (bus.ram_ready) begin
                        state      <= IDLE;
                        last_grant <= ICACHE;
                    end
                end
                DACC: begin
                    if (!d_pend) begin
                        state <= IDLE;
                    end else if (bus.ram_ready) begin
                        state      <= IDLE;
                        last_grant <= DCACHE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the state and the live request/ready inputs: the RAM address
    // follows the granted requester, aborts drop the strobes immediately, and completion is
    // reported in the very cycle ram_ready arrives. Reset forces IDLE, which decodes to the
    // all-idle output values.
    assign bus.ramREN   = i_live | (d_live & ~d_wr);
    assign bus.ramWEN   = d_live & d_wr;
    assign bus.ramaddr  = i_live ? bus.iaddr :
                          d_live ? bus.daddr : {WORD_W{1'b0}};
    assign bus.ramstore = (d_live && d_wr) ? bus.dstore : {WORD_W{1'b0}};

    assign bus.iwait = ~(i_live & bus.ram_ready);
    assign bus.dwait = ~(d_live & bus.ram_ready);

    // Loads are forced to zero outside their completion cycle; a dcache write returns zero.
    assign bus.iload = (i_live && bus.ram_ready) ? bus.ramload : {WORD_W{1'b0}};
    assign bus.dload = (d_live && bus.ram_ready && !d_wr) ? bus.ramload : {WORD_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int W   = 32;
    localparam int INF = 32'h7fff_ffff;

    logic CLK = 1'b0;
    logic RST;

    mem_arbiter_if #(.WORD_W(W)) bus();

    mem_arbiter #(.WORD_W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference memory model ----------------
    logic [31:0] ram_mem [bit [31:0]];   // contents seen by the RAM model
    logic [31:0] ref_mem [bit [31:0]];   // contents predicted by the scoreboard

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    typedef struct { logic [31:0] addr; logic [31:0] data; } iexp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } dexp_t;

    iexp_t iq[$];
    dexp_t dq[$];

    // Arbitration history of the model: 0 = icache served last, 1 = dcache served last.
    int last_done    = 0;
    int i_pend_since = INF;
    int d_pend_since = INF;

    // ---------------- RAM model ----------------
    int ram_fix_lat = 0;    // >= 0: fixed latency, < 0: random in 0..ram_max_lat
    int ram_max_lat = 0;
    int spur_mode   = 0;    // 0 none, 1 random, 2 always ready when idle
    int ram_cnt     = 0;
    int ram_lat     = 0;

    initial begin
        bus.ram_ready = 1'b0;
        bus.ramload   = '0;
        forever begin
            @(negedge CLK);
            if (!RST && (bus.ramREN || bus.ramWEN)) begin
                if (ram_cnt == 0)
                    ram_lat = (ram_fix_lat >= 0) ? ram_fix_lat : int'($urandom_range(ram_max_lat, 0));
                if (ram_cnt >= ram_lat) begin
                    bus.ram_ready = 1'b1;
                    bus.ramload   = bus.ramREN ? ram_rd(bus.ramaddr) : $urandom;
                    if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
                    ram_cnt = 0;
                end else begin
                    bus.ram_ready = 1'b0;
                    bus.ramload   = $urandom;
                    ram_cnt++;
                end
            end else begin
                ram_cnt       = 0;
                bus.ramload   = $urandom;
                bus.ram_ready = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(7, 0) == 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        iexp_t       ie;
        dexp_t       de;
        int          strobe_start;
        int          grant;
        bit          prev_strobe;
        logic [3:0]  viol;
        strobe_start = 0;
        prev_strobe  = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                prev_strobe = 1'b0;
            end else begin
                viol = {bus.ramREN & bus.ramWEN,
                        bus.iwait & (bus.iload != 0),
                        bus.dwait & (bus.dload != 0),
                        ~bus.iwait & ~bus.dwait};
                chk("invariants", {28'b0, viol}, 32'd0);

                if (bus.ramREN || bus.ramWEN) begin
                    if (!prev_strobe) strobe_start = cyc;
                    prev_strobe = 1'b1;
                end else begin
                    prev_strobe = 1'b0;
                end
                grant = strobe_start - 1;

                if (!bus.iwait) begin
                    if (iq.size() == 0) begin
                        chk("i_unexpected_completion", {31'b0, bus.iwait}, 32'd1);
                    end else begin
                        ie = iq.pop_front();
                        chk("i_load", bus.iload, ie.data);
                        chk("i_ramaddr", bus.ramaddr, ie.addr);
                        chk("i_strobes", {30'b0, bus.ramREN, bus.ramWEN}, 32'd2);
                        // dcache waiting at grant time with icache served last -> icache must not win.
                        chk("i_fairness", {31'b0, (last_done == 0) && (d_pend_since <= grant)}, 32'd0);
                    end
                    last_done    = 0;
                    i_pend_since = cyc + 1;
                end

                if (!bus.dwait) begin
                    if (dq.size() == 0) begin
                        chk("d_unexpected_completion", {31'b0, bus.dwait}, 32'd1);
                    end else begin
                        de = dq.pop_front();
                        chk("d_strobes", {30'b0, bus.ramREN, bus.ramWEN}, de.wr ? 32'd1 : 32'd2);
                        chk("d_ramaddr", bus.ramaddr, de.addr);
                        chk("d_load", bus.dload, de.wr ? 32'd0 : de.data);
                        if (de.wr) chk("d_ramstore", bus.ramstore, de.data);
                        chk("d_fairness", {31'b0, (last_done == 1) && (i_pend_since <= grant)}, 32'd0);
                    end
                    last_done    = 1;
                    d_pend_since = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
        #2;
    endtask

    task automatic set_i(input bit en, input logic [31:0] a);
        bus.iREN     = en;
        bus.iaddr    = a;
        i_pend_since = en ? cyc : INF;
    endtask

    task automatic set_d(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] s);
        bus.dREN     = ren;
        bus.dWEN     = wen;
        bus.daddr    = a;
        bus.dstore   = s;
        d_pend_since = (ren || wen) ? cyc : INF;
    endtask

    task automatic assert_reset();
        RST = 1'b1;
        #1;
        chk("rst_iwait",    {31'b0, bus.iwait},  32'd1);
        chk("rst_dwait",    {31'b0, bus.dwait},  32'd1);
        chk("rst_iload",    bus.iload,           32'd0);
        chk("rst_dload",    bus.dload,           32'd0);
        chk("rst_ramREN",   {31'b0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN",   {31'b0, bus.ramWEN}, 32'd0);
        chk("rst_ramaddr",  bus.ramaddr,         32'd0);
        chk("rst_ramstore", bus.ramstore,        32'd0);
        set_i(1'b0, '0);
        set_d(1'b0, 1'b0, '0, '0);
        iq.delete();
        dq.delete();
        last_done = 0;
    endtask

    // Returns at posedge+1 with reset released: the arbiter is IDLE in this cycle.
    task automatic do_reset();
        assert_reset();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_i();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            smp();
            if (!bus.iwait) done = 1'b1;
            tick();
        end
        chk("i_handshake_done", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_d();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            smp();
            if (!bus.dwait) done = 1'b1;
            tick();
        end
        chk("d_handshake_done", {31'b0, done}, 32'd1);
    endtask

    task automatic i_proc(input int n);
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            int idle = $urandom_range(3, 0);
            if (idle != 0) begin
                set_i(1'b0, '0);
                repeat (idle) tick();
            end
            a = $urandom_range(255, 0);
            set_i(1'b1, a);
            iq.push_back('{addr: a, data: ref_rd(a)});
            wait_i();
        end
        set_i(1'b0, '0);
    endtask

    task automatic d_proc(input int n);
        logic [31:0] a;
        logic [31:0] s;
        for (int t = 0; t < n; t++) begin
            int idle = $urandom_range(3, 0);
            int kind = $urandom_range(2, 0);
            if (idle != 0) begin
                set_d(1'b0, 1'b0, '0, '0);
                repeat (idle) tick();
            end
            a = 32'h100 + $urandom_range(15, 0);
            s = $urandom;
            if (kind == 0) begin
                set_d(1'b1, 1'b0, a, s);
                dq.push_back('{wr: 1'b0, addr: a, data: ref_rd(a)});
            end else begin
                ref_mem[a] = s;
                set_d(kind == 2, 1'b1, a, s);
                dq.push_back('{wr: 1'b1, addr: a, data: s});
            end
            wait_d();
        end
        set_d(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        RST = 1'b1;
        set_i(1'b0, '0);
        set_d(1'b0, 1'b0, '0, '0);
        spur_mode   = 0;
        ram_fix_lat = 0;
        #2;

        // Single icache read, RAM ready two cycles after the strobe.
        do_reset();
        ram_fix_lat = 2;
        ram_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        set_i(1'b1, 32'h40);
        iq.push_back('{addr: 32'h40, data: 32'hDEAD_BEEF});
        for (int c = 0; c < 5; c++) begin
            if (c == 4) set_i(1'b0, '0);
            smp();
            chk("t1_iwait",  {31'b0, bus.iwait},  (c == 3) ? 32'd0 : 32'd1);
            chk("t1_iload",  bus.iload,           (c == 3) ? 32'hDEAD_BEEF : 32'd0);
            chk("t1_ramREN", {31'b0, bus.ramREN}, (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
            chk("t1_dwait",  {31'b0, bus.dwait},  32'd1);
            if (c >= 1 && c <= 3) chk("t1_ramaddr", bus.ramaddr, 32'h40);
            tick();
        end

        // dcache write, zero-wait RAM.
        ram_fix_lat = 0;
        ref_mem[32'h100] = 32'h1234_5678;
        set_d(1'b0, 1'b1, 32'h100, 32'h1234_5678);
        dq.push_back('{wr: 1'b1, addr: 32'h100, data: 32'h1234_5678});
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_d(1'b0, 1'b0, '0, '0);
            smp();
            chk("t2_dwait",  {31'b0, bus.dwait},  (c == 1) ? 32'd0 : 32'd1);
            chk("t2_ramWEN", {31'b0, bus.ramWEN}, (c == 1) ? 32'd1 : 32'd0);
            chk("t2_ramREN", {31'b0, bus.ramREN}, 32'd0);
            chk("t2_dload",  bus.dload,           32'd0);
            if (c == 1) chk("t2_ramstore", bus.ramstore, 32'h1234_5678);
            tick();
        end

        // Conflict fairness from reset: D, I, D, I on cycles 1, 3, 5, 7.
        do_reset();
        ram_fix_lat = 0;
        set_i(1'b1, 32'h10);
        set_d(1'b1, 1'b0, 32'h104, '0);
        repeat (2) begin
            iq.push_back('{addr: 32'h10, data: ref_rd(32'h10)});
            dq.push_back('{wr: 1'b0, addr: 32'h104, data: ref_rd(32'h104)});
        end
        for (int c = 0; c < 9; c++) begin
            if (c == 8) begin
                set_i(1'b0, '0);
                set_d(1'b0, 1'b0, '0, '0);
            end
            smp();
            chk("t3_iwait", {31'b0, bus.iwait}, (c == 3 || c == 7) ? 32'd0 : 32'd1);
            chk("t3_dwait", {31'b0, bus.dwait}, (c == 1 || c == 5) ? 32'd0 : 32'd1);
            tick();
        end

        // Abort: D served first, then an icache access aborted; the next conflict goes to I.
        do_reset();
        ram_fix_lat = 0;
        set_d(1'b1, 1'b0, 32'h108, '0);
        dq.push_back('{wr: 1'b0, addr: 32'h108, data: ref_rd(32'h108)});
        smp(); tick();
        smp(); chk("t4_d_done", {31'b0, bus.dwait}, 32'd0); tick();
        set_d(1'b0, 1'b0, '0, '0);
        set_i(1'b1, 32'h20);
        ram_fix_lat = 5;
        smp(); chk("t4_idle_strobe", {31'b0, bus.ramREN}, 32'd0); tick();
        smp(); chk("t4_iacc_strobe", {31'b0, bus.ramREN}, 32'd1);
        chk("t4_iacc_addr", bus.ramaddr, 32'h20); tick();
        set_i(1'b0, '0);
        smp(); chk("t4_abort_strobe", {31'b0, bus.ramREN}, 32'd0);
        chk("t4_abort_iwait", {31'b0, bus.iwait}, 32'd1); tick();
        ram_fix_lat = 0;
        set_i(1'b1, 32'h24);
        set_d(1'b1, 1'b0, 32'h10C, '0);
        iq.push_back('{addr: 32'h24, data: ref_rd(32'h24)});
        dq.push_back('{wr: 1'b0, addr: 32'h10C, data: ref_rd(32'h10C)});
        smp(); chk("t4_back_idle", {31'b0, bus.ramREN}, 32'd0); tick();
        smp(); chk("t4_i_wins", {31'b0, bus.iwait}, 32'd0);
        chk("t4_d_waits", {31'b0, bus.dwait}, 32'd1); tick();
        set_i(1'b0, '0);
        smp(); tick();
        smp(); chk("t4_d_after", {31'b0, bus.dwait}, 32'd0); tick();
        set_d(1'b0, 1'b0, '0, '0);

        // Reset in the middle of a dcache access.
        ram_fix_lat = 5;
        set_d(1'b1, 1'b0, 32'h104, '0);
        dq.push_back('{wr: 1'b0, addr: 32'h104, data: ref_rd(32'h104)});
        smp(); tick();
        smp(); chk("t5_dacc_strobe", {31'b0, bus.ramREN}, 32'd1);
        #1;
        assert_reset();
        tick();
        tick();
        RST = 1'b0;
        ram_fix_lat = 0;
        set_i(1'b1, 32'h28);
        set_d(1'b1, 1'b0, 32'h104, '0);
        iq.push_back('{addr: 32'h28, data: ref_rd(32'h28)});
        dq.push_back('{wr: 1'b0, addr: 32'h104, data: ref_rd(32'h104)});
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_d(1'b0, 1'b0, '0, '0);
            if (c == 4) set_i(1'b0, '0);
            smp();
            chk("t5_dwait", {31'b0, bus.dwait}, (c == 1) ? 32'd0 : 32'd1);
            chk("t5_iwait", {31'b0, bus.iwait}, (c == 3) ? 32'd0 : 32'd1);
            tick();
        end

        // Spurious ram_ready while idle.
        spur_mode = 2;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk("t6_iwait",   {31'b0, bus.iwait}, 32'd1);
            chk("t6_dwait",   {31'b0, bus.dwait}, 32'd1);
            chk("t6_strobes", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
            tick();
        end
        spur_mode = 0;
        set_i(1'b1, 32'h30);
        iq.push_back('{addr: 32'h30, data: ref_rd(32'h30)});
        smp(); chk("t6_still_idle", {31'b0, bus.ramREN}, 32'd0); tick();
        smp(); chk("t6_i_done", {31'b0, bus.iwait}, 32'd0); tick();
        set_i(1'b0, '0);
        tick();

        // Randomized concurrent traffic with random RAM latency and spurious readies.
        do_reset();
        ram_fix_lat = -1;
        ram_max_lat = 3;
        spur_mode   = 1;
        fork
            i_proc(60);
            d_proc(60);
        join
        repeat (3) tick();
        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
